// File: rtl/lcd_pkg.sv
// lcd_pkg: shared types and constants for the HD44780-style LCD write controller.
//   - lcd_state_e   : controller FSM state encoding
//   - CMD_*         : LCD command bytes used by the controller
//   - INIT_ROM      : power-up init command sequence (INIT_LEN entries)
//   - init_rom()    : safe indexed access to INIT_ROM
//   - is_long_cmd() : selects the long (clear/home) execution wait
//   - max_int()     : helper used to size the shared timer
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_POWERUP = 3'd0,
        ST_INIT    = 3'd1,
        ST_IDLE    = 3'd2,
        ST_SETUP   = 3'd3,
        ST_PULSE   = 3'd4,
        ST_HOLD    = 3'd5,
        ST_WAIT    = 3'd6
    } lcd_state_e;

    localparam logic [7:0] CMD_CLEAR     = 8'h01;
    localparam logic [7:0] CMD_HOME      = 8'h02;
    localparam logic [7:0] CMD_FUNC_8B2L = 8'h38;
    localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
    localparam logic [7:0] CMD_ENTRY_INC = 8'h06;

    localparam int INIT_LEN = 6;

    localparam logic [7:0] INIT_ROM [INIT_LEN] = '{
        CMD_FUNC_8B2L, CMD_FUNC_8B2L, CMD_FUNC_8B2L,
        CMD_DISP_ON, CMD_CLEAR, CMD_ENTRY_INC
    };

    // Indexed ROM read; out-of-range indices return 0 rather than X.
    function automatic logic [7:0] init_rom(input logic [2:0] idx);
        logic [7:0] val;
        case (idx)
            3'd0:    val = INIT_ROM[0];
            3'd1:    val = INIT_ROM[1];
            3'd2:    val = INIT_ROM[2];
            3'd3:    val = INIT_ROM[3];
            3'd4:    val = INIT_ROM[4];
            3'd5:    val = INIT_ROM[5];
            default: val = 8'h00;
        endcase
        return val;
    endfunction

    // Clear/home (0x01..0x03 as commands) need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return (rs == 1'b0) &&
               ((data == CMD_CLEAR) || (data == CMD_HOME) || (data == 8'h03));
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lcd_timer.sv
// lcd_timer: load/count/done down-counter shared by every timed FSM state.
//   i_clk      : clock
//   i_reset    : asynchronous active-high reset (count cleared)
//   i_load     : load i_load_val this edge (takes priority over counting)
//   i_load_val : value to load (duration minus one)
//   o_done     : count has reached zero; the counter stops there, never wraps
module lcd_timer #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_done
);

    logic [WIDTH-1:0] count_r;

    // Down-counter: load has priority, otherwise decrement until zero and hold.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count_r <= {WIDTH{1'b0}};
        end else if (i_load) begin
            count_r <= i_load_val;
        end else if (count_r != {WIDTH{1'b0}}) begin
            count_r <= count_r - {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign o_done = (count_r == {WIDTH{1'b0}});

endmodule

// File: rtl/lcd_write_ctrl.sv
// lcd_write_ctrl: drives an HD44780-style 8-bit write-only LCD bus from a
// valid/ready write port, with setup / enable-pulse / hold / execution timing.
//
// Optional feature macro: LCD_INIT_SEQ_EN
//   defined   : after reset wait T_POWERUP cycles, then replay the built-in
//               init ROM before accepting writes.
//   undefined : no power-up wait or init; the FSM reaches IDLE on the first
//               edge after reset and o_init_done is set from that edge.
//
// Ports:
//   i_clk, i_reset        : clock, asynchronous active-high reset
//   i_wr_vld/rs/data      : write request (rs 0 = command, 1 = data)
//   o_wr_rdy              : high only in IDLE; a write is accepted on vld & rdy
//   o_init_done           : init complete, sticky until reset
//   o_lcd_on              : LCD power enable, 1 from the first edge after reset
//   o_lcd_en/rs/rw/data   : LCD bus (rw tied to 0)
//
// All outputs are registered and computed from the next state, so each bus
// phase lasts exactly its programmed number of cycles.
module lcd_write_ctrl
    import lcd_pkg::*;
#(
    parameter int T_SETUP    = 2,
    parameter int T_EN       = 12,
    parameter int T_HOLD     = 2,
    parameter int T_CMD_WAIT = 2000,
    parameter int T_CLR_WAIT = 80000,
    parameter int T_POWERUP  = 750000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_wr_vld,
    input  logic       i_wr_rs,
    input  logic [7:0] i_wr_data,
    output logic       o_wr_rdy,
    output logic       o_init_done,
    output logic       o_lcd_on,
    output logic       o_lcd_en,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic [7:0] o_lcd_data
);

    localparam int T_MAX = max_int(max_int(max_int(T_SETUP, T_EN), max_int(T_HOLD, T_CMD_WAIT)),
                                   max_int(T_CLR_WAIT, T_POWERUP));
    localparam int TW    = $clog2(T_MAX) + 1;

    lcd_state_e    state_r, state_s;
    logic          lcd_rs_r, lcd_rs_s;
    logic [7:0]    lcd_data_r, lcd_data_s;
    logic          lcd_en_r;
    logic          wr_rdy_r;
    logic          init_done_r, init_done_s;
    logic          lcd_on_r;
    logic          tmr_load_s;
    logic [TW-1:0] tmr_val_s;
    logic          tmr_done_s;

`ifdef LCD_INIT_SEQ_EN
    logic [2:0]    step_r, step_s;
    // armed_r marks that the power-up count has been loaded; the timer
    // comes out of reset at zero, so the first POWERUP edge loads it.
    logic          armed_r, armed_s;
`endif

    lcd_timer #(
        .WIDTH (TW)
    ) u_timer (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (tmr_load_s),
        .i_load_val (tmr_val_s),
        .o_done     (tmr_done_s)
    );

    // Next-state, latched bus values and timer control.
    always_comb begin
        state_s     = state_r;
        lcd_rs_s    = lcd_rs_r;
        lcd_data_s  = lcd_data_r;
        init_done_s = init_done_r;
        tmr_load_s  = 1'b0;
        tmr_val_s   = {TW{1'b0}};
`ifdef LCD_INIT_SEQ_EN
        step_s      = step_r;
        armed_s     = armed_r;
`endif
        case (state_r)
            ST_POWERUP: begin
`ifdef LCD_INIT_SEQ_EN
                if (!armed_r) begin
                    armed_s    = 1'b1;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = TW'(T_POWERUP - 1);
                end else if (tmr_done_s) begin
                    state_s = ST_INIT;
                    step_s  = 3'd0;
                end else begin
                    state_s = ST_POWERUP;
                end
`else
                state_s     = ST_IDLE;
                init_done_s = 1'b1;
`endif
            end
            ST_INIT: begin
`ifdef LCD_INIT_SEQ_EN
                lcd_rs_s   = 1'b0;
                lcd_data_s = init_rom(step_r);
                state_s    = ST_SETUP;
                tmr_load_s = 1'b1;
                tmr_val_s  = TW'(T_SETUP - 1);
`else
                state_s    = ST_IDLE;
`endif
            end
            ST_IDLE: begin
                // wr_rdy_r is only high in IDLE, so a vld arriving on the
                // edge that enters IDLE waits for the next edge.
                if (i_wr_vld && wr_rdy_r) begin
                    lcd_rs_s   = i_wr_rs;
                    lcd_data_s = i_wr_data;
                    state_s    = ST_SETUP;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = TW'(T_SETUP - 1);
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (tmr_done_s) begin
                    state_s    = ST_PULSE;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = TW'(T_EN - 1);
                end else begin
                    state_s = ST_SETUP;
                end
            end
            ST_PULSE: begin
                if (tmr_done_s) begin
                    state_s    = ST_HOLD;
                    tmr_load_s = 1'b1;
                    tmr_val_s  = TW'(T_HOLD - 1);
                end else begin
                    state_s = ST_PULSE;
                end
            end
            ST_HOLD: begin
                if (tmr_done_s) begin
                    state_s    = ST_WAIT;
                    tmr_load_s = 1'b1;
                    if (is_long_cmd(lcd_rs_r, lcd_data_r)) begin
                        tmr_val_s = TW'(T_CLR_WAIT - 1);
                    end else begin
                        tmr_val_s = TW'(T_CMD_WAIT - 1);
                    end
                end else begin
                    state_s = ST_HOLD;
                end
            end
            ST_WAIT: begin
                if (tmr_done_s) begin
`ifdef LCD_INIT_SEQ_EN
                    if (init_done_r) begin
                        state_s = ST_IDLE;
                    end else if (step_r == 3'(INIT_LEN - 1)) begin
                        state_s     = ST_IDLE;
                        init_done_s = 1'b1;
                    end else begin
                        state_s = ST_INIT;
                        step_s  = step_r + 3'd1;
                    end
`else
                    state_s = ST_IDLE;
`endif
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: begin
                state_s = ST_POWERUP;
            end
        endcase
    end

    // State and registered outputs; EN/ready are decoded from the next state.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_r     <= ST_POWERUP;
            lcd_rs_r    <= 1'b0;
            lcd_data_r  <= 8'h00;
            lcd_en_r    <= 1'b0;
            wr_rdy_r    <= 1'b0;
            init_done_r <= 1'b0;
            lcd_on_r    <= 1'b0;
        end else begin
            state_r     <= state_s;
            lcd_rs_r    <= lcd_rs_s;
            lcd_data_r  <= lcd_data_s;
            lcd_en_r    <= (state_s == ST_PULSE);
            wr_rdy_r    <= (state_s == ST_IDLE);
            init_done_r <= init_done_s;
            lcd_on_r    <= 1'b1;
        end
    end

`ifdef LCD_INIT_SEQ_EN
    // Init sequencing registers.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            step_r  <= 3'd0;
            armed_r <= 1'b0;
        end else begin
            step_r  <= step_s;
            armed_r <= armed_s;
        end
    end
`endif

    assign o_wr_rdy    = wr_rdy_r;
    assign o_init_done = init_done_r;
    assign o_lcd_on    = lcd_on_r;
    assign o_lcd_en    = lcd_en_r;
    assign o_lcd_rs    = lcd_rs_r;
    assign o_lcd_rw    = 1'b0;
    assign o_lcd_data  = lcd_data_r;

endmodule

// File: tb/tb_lcd_write_ctrl.sv
// tb_lcd_write_ctrl: directed, table-driven bench for lcd_write_ctrl with
// shortened timing (setup 2, enable 4, hold 2, cmd wait 10, clear wait 40,
// power-up 20). Covers both builds of LCD_INIT_SEQ_EN.
module tb_lcd_write_ctrl;

    localparam int P_SETUP = 2;
    localparam int P_EN    = 4;
    localparam int P_HOLD  = 2;
    localparam int P_CMD   = 10;
    localparam int P_CLR   = 40;
    localparam int P_PWR   = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_vld = 1'b0;
    logic       wr_rs = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       wr_rdy, init_done, lcd_on, lcd_en, lcd_rs, lcd_rw;
    logic [7:0] lcd_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         lat;
    } wr_vec_t;

    wr_vec_t vecs [8];

    lcd_write_ctrl #(
        .T_SETUP    (P_SETUP),
        .T_EN       (P_EN),
        .T_HOLD     (P_HOLD),
        .T_CMD_WAIT (P_CMD),
        .T_CLR_WAIT (P_CLR),
        .T_POWERUP  (P_PWR)
    ) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_wr_vld    (wr_vld),
        .i_wr_rs     (wr_rs),
        .i_wr_data   (wr_data),
        .o_wr_rdy    (wr_rdy),
        .o_init_done (init_done),
        .o_lcd_on    (lcd_on),
        .o_lcd_en    (lcd_en),
        .o_lcd_rs    (lcd_rs),
        .o_lcd_rw    (lcd_rw),
        .o_lcd_data  (lcd_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_en"},   {31'd0, lcd_en},    32'd0);
        check({tag, "_rdy"},  {31'd0, wr_rdy},    32'd0);
        check({tag, "_done"}, {31'd0, init_done}, 32'd0);
        check({tag, "_on"},   {31'd0, lcd_on},    32'd0);
        check({tag, "_rs"},   {31'd0, lcd_rs},    32'd0);
        check({tag, "_rw"},   {31'd0, lcd_rw},    32'd0);
        check({tag, "_data"}, {24'd0, lcd_data},  32'd0);
    endtask

    // Wait (bounded) for ready at a negedge, present the write, step to k=0.
    task automatic issue(input logic rs, input logic [7:0] d);
        int n = 0;
        while (!wr_rdy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("rdy_wait", {31'd0, wr_rdy}, 32'd1);
        wr_vld  = 1'b1;
        wr_rs   = rs;
        wr_data = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    // From interval k=0 after acceptance, check the bus cycle by cycle up
    // to the cycle where ready returns (k == lat).
    task automatic track(input logic rs, input logic [7:0] d, input int lat,
                         input bit keep, input logic nrs, input logic [7:0] nd);
        for (int k = 0; k <= lat; k++) begin
            if (k == 0) begin
                if (keep) begin
                    wr_vld  = 1'b1;
                    wr_rs   = nrs;
                    wr_data = nd;
                end else begin
                    wr_vld = 1'b0;
                end
            end
            check($sformatf("en_k%0d_d%0h", k, d), {31'd0, lcd_en},
                  {31'd0, (k >= P_SETUP && k < P_SETUP + P_EN)});
            check($sformatf("rdy_k%0d_d%0h", k, d), {31'd0, wr_rdy}, {31'd0, (k == lat)});
            check($sformatf("data_k%0d", k), {24'd0, lcd_data}, {24'd0, d});
            check($sformatf("rs_k%0d", k), {31'd0, lcd_rs}, {31'd0, rs});
            if (k < lat) @(negedge clk);
        end
    endtask

`ifdef LCD_INIT_SEQ_EN
    // Watch the power-up init sequence; pulses vld with 0x55 during POWERUP.
    task automatic run_init_check();
        logic [7:0] rom [6];
        int  pulses = 0;
        int  width = 0;
        int  gap = 0;
        int  first_rise = -1;
        int  gaps [6];
        logic prev_en = 1'b0;
        bit  seen55 = 1'b0;
        bit  rdy_early = 1'b0;
        rom = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
        for (int i = 0; i < 6; i++) gaps[i] = 0;
        for (int cyc = 1; cyc < 3000; cyc++) begin
            if (cyc == 3) begin
                wr_vld = 1'b1; wr_rs = 1'b1; wr_data = 8'h55;
            end else begin
                wr_vld = 1'b0;
            end
            @(negedge clk);
            if (lcd_data == 8'h55) seen55 = 1'b1;
            if (wr_rdy && !init_done) rdy_early = 1'b1;
            if (lcd_en) begin
                if (!prev_en) begin
                    if (first_rise < 0) first_rise = cyc;
                    if (pulses < 6) begin
                        check($sformatf("init_data_%0d", pulses), {24'd0, lcd_data}, {24'd0, rom[pulses]});
                        check($sformatf("init_rs_%0d", pulses), {31'd0, lcd_rs}, 32'd0);
                    end
                    if (pulses > 0 && pulses < 7) gaps[pulses-1] = gap;
                    width = 0;
                end
                width++;
            end else begin
                if (prev_en) begin
                    check($sformatf("init_width_%0d", pulses), width, P_EN);
                    pulses++;
                    gap = 0;
                end
                gap++;
            end
            prev_en = lcd_en;
            if (pulses == 6 && init_done) break;
        end
        wr_vld = 1'b0;
        check("init_pulses", pulses, 6);
        check("init_powerup_wait", {31'd0, (first_rise > P_PWR)}, 32'd1);
        check("init_clr_gap", gaps[4] - gaps[3], P_CLR - P_CMD);
        check("init_cmd_gap", gaps[3], gaps[2]);
        check("init_no_55", {31'd0, seen55}, 32'd0);
        check("init_rdy_early", {31'd0, rdy_early}, 32'd0);
        check("init_done", {31'd0, init_done}, 32'd1);
        check("init_rdy", {31'd0, wr_rdy}, 32'd1);
        check("init_en_low", {31'd0, lcd_en}, 32'd0);
    endtask
`endif

    // Called right after reset release at a negedge.
    task automatic post_release();
        #1;
        check("on_before_edge", {31'd0, lcd_on}, 32'd0);
        @(negedge clk);
        check("on_after_edge", {31'd0, lcd_on}, 32'd1);
`ifdef LCD_INIT_SEQ_EN
        check("done_during_pwr", {31'd0, init_done}, 32'd0);
        run_init_check();
`else
        check("done_first_edge", {31'd0, init_done}, 32'd1);
        check("rdy_first_edge", {31'd0, wr_rdy}, 32'd1);
`endif
    endtask

    initial begin
        vecs[0] = '{1'b1, 8'h41, 18};
        vecs[1] = '{1'b0, 8'h38, 18};
        vecs[2] = '{1'b0, 8'h01, 48};
        vecs[3] = '{1'b0, 8'h02, 48};
        vecs[4] = '{1'b0, 8'h03, 48};
        vecs[5] = '{1'b0, 8'h04, 18};
        vecs[6] = '{1'b1, 8'h01, 18};
        vecs[7] = '{1'b0, 8'h00, 18};

        // Reset state.
        repeat (3) @(negedge clk);
        check_all_zero("rst");
        rst = 1'b0;
        post_release();

        // Table-driven single writes.
        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].rs, vecs[i].data);
            track(vecs[i].rs, vecs[i].data, vecs[i].lat, 1'b0, 1'b0, 8'h00);
        end

        // Back-to-back: clear then 0x80 with vld held throughout.
        issue(1'b0, 8'h01);
        track(1'b0, 8'h01, 48, 1'b1, 1'b0, 8'h80);
        @(negedge clk);
        track(1'b0, 8'h80, 18, 1'b0, 1'b0, 8'h00);

        // Reset in the middle of a data write's enable pulse.
        issue(1'b1, 8'h5A);
        wr_vld = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_en_high", {31'd0, lcd_en}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        repeat (2) @(negedge clk);
        check_all_zero("held_rst");
        rst = 1'b0;
        post_release();

        // Normal write after recovery.
        issue(vecs[0].rs, vecs[0].data);
        track(vecs[0].rs, vecs[0].data, vecs[0].lat, 1'b0, 1'b0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_write_ctrl.md
Name: lcd_write_ctrl

Overview:
- Consumer end of the processor's LCD output port: takes character/command writes from the core's LCD I/O register and drives a character LCD bus (HD44780-style, 8-bit, write-only) with correct setup, enable-pulse, hold and execution timing.
- Sits between the core's memory-mapped LCD register and the board pins.
- Issues a built-in power-up init sequence, then serves writes through a valid/ready handshake.

Parameters:
- T_SETUP, 2, cycles RS/DATA are stable before EN rises (>=1)
- T_EN, 12, cycles EN is held high (>=1)
- T_HOLD, 2, cycles RS/DATA are held after EN falls (>=1)
- T_CMD_WAIT, 2000, execution wait for normal commands/data (>=1)
- T_CLR_WAIT, 80000, execution wait for clear/home commands (>=1)
- T_POWERUP, 750000, wait after reset before the first init write (>=1)

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous reset, active-high
- i_wr_vld  in  1  write request from the LCD I/O register
- i_wr_rs  in  1  0 = command, 1 = data
- i_wr_data  in  8  command/character byte
- o_wr_rdy  out  1  ready to accept a write
- o_init_done  out  1  init sequence complete (sticky until reset)
- o_lcd_on  out  1  LCD power/backlight enable
- o_lcd_en  out  1  LCD enable strobe
- o_lcd_rs  out  1  LCD register select
- o_lcd_rw  out  1  LCD read/write, constant 0
- o_lcd_data  out  8  LCD data bus

Behaviour:
- Reset (async, active-high): all outputs 0; FSM enters POWERUP; timer cleared. While i_reset is high, o_lcd_en is 0 immediately, regardless of the clock.
- o_lcd_on goes to 1 on the first clock edge after reset release and stays 1.
- FSM states: POWERUP, INIT, IDLE, SETUP, PULSE, HOLD, WAIT.
- POWERUP: count T_POWERUP cycles, then go to INIT with step index 0.
- INIT: load ROM[step] with rs=0, go to SETUP. The ROM is 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06.
  - After WAIT of the last step (index 5): o_init_done goes to 1, go to IDLE.
  - After WAIT of any earlier step: step+1, go back to INIT.
- IDLE: o_wr_rdy=1 only in IDLE.
  - A write is accepted on an edge where i_wr_vld & o_wr_rdy; i_wr_rs and i_wr_data are latched on that edge.
  - Next state SETUP; o_wr_rdy drops on the same edge.
- SETUP: o_lcd_rs/o_lcd_data show the latched values, EN=0, for T_SETUP cycles.
- PULSE: EN=1 for exactly T_EN cycles, with rs/data unchanged.
- HOLD: EN=0, rs/data unchanged, for T_HOLD cycles.
- WAIT: rs/data unchanged, EN=0.
  - Wait length is T_CLR_WAIT when rs=0 and data in {0x01, 0x02, 0x03}; otherwise T_CMD_WAIT.
  - Then return to IDLE, or to INIT while the init sequence is still running.
- Timing:
  - EN rises T_SETUP cycles after the acceptance edge.
  - o_wr_rdy reasserts T_SETUP+T_EN+T_HOLD+wait cycles after the acceptance edge.
- Boundaries:
  - i_wr_vld outside IDLE (including during POWERUP/INIT) is ignored; the requester holds vld and data stable until accepted.
  - A vld that is high on the same edge the FSM returns to IDLE is not accepted until the following edge.
  - The timer is a down-counter sized to $clog2 of the largest parameter plus 1; it never wraps. Load value is N-1, and the state advances on the count reaching 0.
  - Back-to-back writes: with vld held high, a new acceptance happens on the first IDLE edge, so ready is high for 1 cycle.
  - Reset mid-pulse or mid-init: EN drops to 0 asynchronously, and the full init sequence restarts after release.

Optional Feature:
- LCD_INIT_SEQ_EN
  - Defined: behaviour as above.
  - Undefined: POWERUP and INIT are removed. After reset the FSM enters IDLE on the first edge, o_init_done=1 from that edge, and software issues its own init commands.

Decomposition:
- Package lcd_pkg: state enum typedef; init ROM as a constant array; command constants (CMD_CLEAR=0x01, CMD_HOME=0x02, CMD_FUNC_8B2L=0x38, CMD_DISP_ON=0x0C, CMD_ENTRY_INC=0x06); INIT_LEN=6.
- One sub-module, lcd_timer: load/count/done down-counter, parameter WIDTH; instantiated once and shared by all timed states.

Test Plan (T_SETUP=2, T_EN=4, T_HOLD=2, T_CMD_WAIT=10, T_CLR_WAIT=40, T_POWERUP=20, feature defined):
- Reset release -> 20 idle cycles, then 6 EN pulses of 4 cycles each with data 38,38,38,0C,01,06 and rs=0; the gap after 0x01 is 40 cycles; then o_init_done=1 and o_wr_rdy=1.
- After init, write rs=1 data=0x41 -> EN high on cycles 2..5 after acceptance; o_lcd_data=0x41 and rs=1 from acceptance+1 through HOLD; ready returns at acceptance+18.
- Write rs=0 data=0x01, then rs=0 data=0x80 with vld held -> ready returns at +48 for the clear, +18 for 0x80; the second write is accepted on the first ready cycle.
- Pulse vld for 1 cycle during POWERUP with data=0x55 -> no EN activity beyond the init sequence; 0x55 never appears on o_lcd_data.
- Assert i_reset during the PULSE of a data write -> o_lcd_en=0 with no clock edge, all outputs 0; after release the init sequence replays from step 0.
- Feature undefined: reset release -> o_init_done=1 and o_wr_rdy=1 one edge later; write 0x38 -> single 4-cycle EN pulse, no other bus activity.
